vdp_exec_seq: RTL and testbench
===============================

// Module: vdp_exec_seq
// PURPOSE
//  Execute/write-back sequencer directly upstream of the 4x16 register file.
//  - Accepts 16-bit instruction words over a valid/ready handshake.
//  - Reads operands through the regfile ports (rs->o_b, plus the o_r0..o_r3 taps).
//  - Computes a 16-bit ALU result; MUL takes 16 cycles.
//  - Drives rd/result back into the regfile. The regfile writes r[rd] on every clk edge and has no write enable, so this block rewrites the current value whenever it is not writing.
// PARAMETERS
//  MUL_CYCLES  16  shift-add iterations for MUL; must equal data width
// PORTS
//  clk         in   1   rising-edge clock, shared with regfile
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   instruction word valid
//  in_instr    in   16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
//  in_ready    out  1   high only in IDLE
//  rs          out  2   regfile read select (to regfile rs)
//  rd          out  2   regfile write select (to regfile rd)
//  result      out  16  regfile write data (to regfile result)
//  o_b         in   16  regfile r[rs] read data
//  o_r0..o_r3  in   16  each; regfile direct register taps
//  busy        out  1   instruction in flight (not IDLE)
//  done        out  1   1-cycle pulse on the edge the result is committed
//  flag_z      out  1   zero flag
//  flag_c      out  1   carry/borrow flag
//  err         out  1   1-cycle pulse for an illegal opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; instr latch=0; rs=0; rd=0.
//   done=err=flag_z=flag_c=0; in_ready=1 once reset releases.
//  rd_val = mux(o_r0..o_r3, rd). It is combinational, with no register.
//  Hold rule: in every state except a commit cycle, result=rd_val, so r[rd] rewrites itself.
//  FSM:
//   IDLE: in_ready=1. On in_valid, latch in_instr, go to EXEC. Otherwise stay.
//   EXEC: rs, rd come from the latch.
//    - Single-cycle op: result=ALU(rd_val,o_b,imm). The commit is the EXEC->IDLE edge. done=1 in EXEC.
//    - MUL: load multiplicand=rd_val, multiplier=o_b, acc=0. Go to MUL. The hold rule applies.
//    - Illegal op: err=1, hold rule, go to IDLE.
//   MUL: one shift-add step per cycle, counter 0..MUL_CYCLES-1. At the last count go to WB.
//   WB: result=acc[15:0], done=1. Go to IDLE.
//  Latency: accept edge to commit edge is 1 clk for single-cycle ops and MUL_CYCLES+2 clk for MUL.
//   Back-to-back throughput is one instruction per 2 clk.
//  Ops (all 16-bit, wrap modulo 2^16):
//   0 NOP hold; 1 LDI rd={8'h00,imm}; 2 LDH rd={imm,rd_val[7:0]}
//   3 MOV rd=o_b; 4 ADD rd_val+o_b; 5 SUB rd_val-o_b; 6 AND; 7 OR; 8 XOR
//   9 SHL rd_val<<imm[3:0]; A SHR (logical) rd_val>>imm[3:0]; B MUL low 16 bits
//   C CMP: flags only, hold rule (no write); D-F illegal
//  Flags update only on the commit edge (CMP: the EXEC->IDLE edge):
//   - ADD: c=carry-out. SUB/CMP: c=borrow (rd_val<o_b).
//   - ADD, SUB, CMP, AND, OR, XOR, MUL: z=(value==0). For CMP the value is rd_val-o_b.
//   - Other ops leave both flags unchanged. MUL leaves c unchanged.
//  rd==rs is legal: both operands are the same pre-write value (e.g. ADD r1,r1 doubles).
//  in_valid outside IDLE is ignored; the word is not consumed.
//  Reset mid-MUL: abort, discard acc, no commit. After release, r[0] is rewritten with its own value.
// TESTING
//  1 Reset then LDI r2,0xA5 -> 1 clk later o_r2=0x00A5, done pulsed 1 cycle, others unchanged.
//  2 r0=0xFFFF, r1=0x0001, ADD r0,r1 -> r0=0x0000, flag_z=1, flag_c=1; SUB r1,r0 after -> r1=0x0001, c=0.
//  3 r3=0x0123, r1=0x0100, MUL r3,r1 -> r3=0x2300 exactly 18 clk after accept; in_ready low throughout.
//  4 Idle 50 cycles with r0..r3 preset -> all registers unchanged (hold rule); CMP r2,r2 -> z=1, c=0, r2 unchanged.
//  5 Opcode 0xE -> err 1-cycle pulse, no register/flag change; in_valid held during MUL -> ignored.
//  6 rst_n low mid-MUL (cycle 7) -> target reg keeps its old value, busy=0, in_ready=1 after release.

Source files
------------

// File: rtl/vdp_exec_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vdp_exec_seq
//  Purpose  : Execute / write-back sequencer sitting directly in front of a
//             4 x 16-bit register file. It accepts one instruction word over a
//             valid/ready handshake, reads its operands from the register
//             file, computes a 16-bit result and writes it back through the
//             regfile's rd/result port. MUL uses an iterative shift-add unit.
//
//             The register file writes r[rd] on every clock edge and has no
//             write enable. Whenever this block is not committing a result,
//             it drives result with the current value of r[rd] so that the
//             register simply rewrites itself.
//
//  Ports    : clk        in   rising-edge clock, shared with the regfile
//             rst_n      in   asynchronous active-low reset
//             in_valid   in   instruction word valid
//             in_instr   in   [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
//             in_ready   out  high only while idle
//             rs         out  regfile read select
//             rd         out  regfile write select
//             result     out  regfile write data
//             o_b        in   regfile r[rs] read data
//             o_r0..o_r3 in   regfile direct register taps
//             busy       out  instruction in flight
//             done       out  one-cycle pulse in the cycle before the commit
//                             edge
//             flag_z     out  zero flag
//             flag_c     out  carry / borrow flag
//             err        out  one-cycle pulse for an illegal opcode
//
//  Revision : 1.0  initial release
// ============================================================================
module vdp_exec_seq #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [1:0]  rs,
    output logic [1:0]  rd,
    output logic [15:0] result,
    input  logic [15:0] o_b,
    input  logic [15:0] o_r0,
    input  logic [15:0] o_r1,
    input  logic [15:0] o_r2,
    input  logic [15:0] o_r3,
    output logic        busy,
    output logic        done,
    output logic        flag_z,
    output logic        flag_c,
    output logic        err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(MUL_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_MUL  = 2'd2;
    localparam logic [1:0] c_S_WB   = 2'd3;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDI = 4'h1;
    localparam logic [3:0] c_OP_LDH = 4'h2;
    localparam logic [3:0] c_OP_MOV = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_SUB = 4'h5;
    localparam logic [3:0] c_OP_AND = 4'h6;
    localparam logic [3:0] c_OP_OR  = 4'h7;
    localparam logic [3:0] c_OP_XOR = 4'h8;
    localparam logic [3:0] c_OP_SHL = 4'h9;
    localparam logic [3:0] c_OP_SHR = 4'hA;
    localparam logic [3:0] c_OP_MUL = 4'hB;
    localparam logic [3:0] c_OP_CMP = 4'hC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q,  state_d;
    logic [15:0]   instr_q,  instr_d;
    logic [15:0]   mcand_q,  mcand_d;
    logic [15:0]   mplier_q, mplier_d;
    logic [15:0]   acc_q,    acc_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;

    // ------------------------------------------------------------------
    // Instruction field decode (always from the latch)
    // ------------------------------------------------------------------
    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic [15:0] w_rd_val;

    assign w_op  = instr_q[15:12];
    assign w_imm = instr_q[7:0];
    assign rd    = instr_q[11:10];
    assign rs    = instr_q[9:8];

    // Current content of the destination register, straight from the taps.
    always_comb begin
        case (rd)
            2'd0:    w_rd_val = o_r0;
            2'd1:    w_rd_val = o_r1;
            2'd2:    w_rd_val = o_r2;
            default: w_rd_val = o_r3;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [16:0] w_sum;
    logic [15:0] w_diff;
    logic        w_borrow;
    logic [15:0] w_alu;
    logic [15:0] w_zsrc;     // value the zero flag is taken from
    logic        w_legal;
    logic        w_is_mul;
    logic        w_upd_z;
    logic        w_upd_c;
    logic        w_c_val;

    assign w_sum    = {1'b0, w_rd_val} + {1'b0, o_b};
    assign w_diff   = w_rd_val - o_b;
    assign w_borrow = (w_rd_val < o_b);

    always_comb begin
        w_alu    = w_rd_val;   // NOP and CMP write back the old value
        w_zsrc   = w_rd_val;
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        w_upd_z  = 1'b0;
        w_upd_c  = 1'b0;
        w_c_val  = 1'b0;
        case (w_op)
            c_OP_NOP: ;
            c_OP_LDI: w_alu = {8'h00, w_imm};
            c_OP_LDH: w_alu = {w_imm, w_rd_val[7:0]};
            c_OP_MOV: w_alu = o_b;
            c_OP_ADD: begin
                w_alu   = w_sum[15:0];
                w_zsrc  = w_sum[15:0];
                w_upd_z = 1'b1;
                w_upd_c = 1'b1;
                w_c_val = w_sum[16];
            end
            c_OP_SUB: begin
                w_alu   = w_diff;
                w_zsrc  = w_diff;
                w_upd_z = 1'b1;
                w_upd_c = 1'b1;
                w_c_val = w_borrow;
            end
            c_OP_AND: begin
                w_alu   = w_rd_val & o_b;
                w_zsrc  = w_rd_val & o_b;
                w_upd_z = 1'b1;
            end
            c_OP_OR: begin
                w_alu   = w_rd_val | o_b;
                w_zsrc  = w_rd_val | o_b;
                w_upd_z = 1'b1;
            end
            c_OP_XOR: begin
                w_alu   = w_rd_val ^ o_b;
                w_zsrc  = w_rd_val ^ o_b;
                w_upd_z = 1'b1;
            end
            c_OP_SHL: w_alu = w_rd_val << w_imm[3:0];
            c_OP_SHR: w_alu = w_rd_val >> w_imm[3:0];
            c_OP_MUL: w_is_mul = 1'b1;
            c_OP_CMP: begin
                // Flags only: the destination keeps its value.
                w_zsrc  = w_diff;
                w_upd_z = 1'b1;
                w_upd_c = 1'b1;
                w_c_val = w_borrow;
            end
            default:  w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        result   = w_rd_val;   // hold rule: r[rd] rewrites itself
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            c_S_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = c_S_EXEC;
                end
            end

            c_S_EXEC: begin
                state_d = c_S_IDLE;
                if (!w_legal) begin
                    err = 1'b1;
                end else if (w_is_mul) begin
                    // Operands are captured now; the destination keeps
                    // rewriting itself until write-back.
                    mcand_d  = w_rd_val;
                    mplier_d = o_b;
                    acc_d    = 16'h0000;
                    cnt_d    = '0;
                    state_d  = c_S_MUL;
                end else begin
                    result = w_alu;
                    done   = 1'b1;
                    if (w_upd_z) flag_z_d = (w_zsrc == 16'h0000);
                    if (w_upd_c) flag_c_d = w_c_val;
                end
            end

            c_S_MUL: begin
                // Only the low 16 product bits are kept, so a 16-bit
                // accumulator and a left-shifting multiplicand suffice.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) state_d = c_S_WB;
            end

            default: begin // c_S_WB
                result   = acc_q;
                done     = 1'b1;
                flag_z_d = (acc_q == 16'h0000);
                state_d  = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_S_IDLE;
            instr_q  <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            acc_q    <= 16'h0000;
            cnt_q    <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign in_ready = (state_q == c_S_IDLE);
    assign busy     = (state_q != c_S_IDLE);
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_exec_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vdp_exec_seq
//  Purpose  : Bench for vdp_exec_seq with a behavioural 4x16 register file
//             closing the write-back loop. Hand-written vectors, directed
//             corner sequences and random instructions are compared against
//             an architectural model of registers and flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vdp_exec_seq;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        in_ready, busy, done, flag_z, flag_c, err;
    logic [1:0]  rs, rd;
    logic [15:0] result;
    logic [15:0] o_b, o_r0, o_r1, o_r2, o_r3;

    // Register file: writes r[rd] every edge, no enable, no reset.
    logic [15:0] rf [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    always @(posedge clk) rf[rd] <= result;
    assign o_b  = rf[rs];
    assign o_r0 = rf[0];
    assign o_r1 = rf[1];
    assign o_r2 = rf[2];
    assign o_r3 = rf[3];

    vdp_exec_seq #(.MUL_CYCLES(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .rs       (rs),
        .rd       (rd),
        .result   (result),
        .o_b      (o_b),
        .o_r0     (o_r0),
        .o_r1     (o_r1),
        .o_r2     (o_r2),
        .o_r3     (o_r3),
        .busy     (busy),
        .done     (done),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model
    logic [15:0] m [4];
    logic        mz, mc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Instruction effect on registers and flags, straight from the ISA rules.
    task automatic model_apply(input logic [15:0] ins);
        int unsigned a, b, v;
        logic [3:0] op;
        logic [1:0] d, s;
        logic [7:0] imm;
        op = ins[15:12]; d = ins[11:10]; s = ins[9:8]; imm = ins[7:0];
        a = m[d]; b = m[s];
        case (op)
            4'h1: m[d] = {8'h00, imm};
            4'h2: m[d] = {imm, m[d][7:0]};
            4'h3: m[d] = b[15:0];
            4'h4: begin v = a + b; m[d] = v[15:0]; mz = (v % 65536) == 0; mc = v > 65535; end
            4'h5: begin v = (a - b) % 65536; m[d] = v[15:0]; mz = v == 0; mc = a < b; end
            4'h6: begin v = a & b; m[d] = v[15:0]; mz = v == 0; end
            4'h7: begin v = a | b; m[d] = v[15:0]; mz = v == 0; end
            4'h8: begin v = a ^ b; m[d] = v[15:0]; mz = v == 0; end
            4'h9: begin v = (a << imm[3:0]) % 65536; m[d] = v[15:0]; end
            4'hA: begin v = a >> imm[3:0]; m[d] = v[15:0]; end
            4'hB: begin v = (a * b) % 65536; m[d] = v[15:0]; mz = v == 0; end
            4'hC: begin mz = ((a - b) % 65536) == 0; mc = a < b; end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_r0"}, rf[0], m[0]);
        chk({tag, "_r1"}, rf[1], m[1]);
        chk({tag, "_r2"}, rf[2], m[2]);
        chk({tag, "_r3"}, rf[3], m[3]);
        chk({tag, "_z"}, flag_z, mz);
        chk({tag, "_c"}, flag_c, mc);
    endtask

    // Issue one instruction and follow it to completion. With hold set,
    // in_valid stays high (with a different word) while the block is busy.
    task automatic run(input logic [15:0] ins, input bit hold);
        int busy_n, done_n, err_n, done_at, exp_busy;
        bit fin, illegal;
        @(negedge clk);
        chk("ready_before", in_ready, 1);
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        #1;
        if (hold) in_instr = 16'h10FF;
        else      in_valid = 1'b0;
        busy_n = 0; done_n = 0; err_n = 0; done_at = 0; fin = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            @(negedge clk);
            if (done) begin done_n++; done_at = k; end
            if (err) err_n++;
            if (in_ready) begin fin = 1'b1; in_valid = 1'b0; end
            else busy_n++;
        end
        in_valid = 1'b0;
        chk("complete", fin, 1);
        model_apply(ins);
        illegal  = (ins[15:12] >= 4'hD);
        exp_busy = (ins[15:12] == 4'hB) ? 18 : 1;
        chk("busy_cycles", busy_n, exp_busy);
        chk("done_count", done_n, illegal ? 0 : 1);
        chk("err_count", err_n, illegal ? 1 : 0);
        if (!illegal) chk("latency", done_at, exp_busy);
        chk("busy_low", busy, 0);
        chk_state("post");
    endtask

    task automatic load(input logic [1:0] r, input logic [15:0] v);
        run({4'h1, r, 2'b00, v[7:0]}, 1'b0);
        run({4'h2, r, 2'b00, v[15:8]}, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm;
        logic [15:0] a, b, ev;
        bit          cz, ez, cc, ec;
    } vec_t;

    vec_t vt [17];

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 16'h0000;
        mz = 1'b0; mc = 1'b0;

        //          op    rd    rs    imm     a         b         expected  cz ez cc ec
        vt[0]  = '{4'h4, 2'd0, 2'd1, 8'h00, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1, 1};
        vt[1]  = '{4'h5, 2'd1, 2'd0, 8'h00, 16'h0001, 16'h0000, 16'h0001, 1, 0, 1, 0};
        vt[2]  = '{4'hB, 2'd3, 2'd1, 8'h00, 16'h0123, 16'h0100, 16'h2300, 1, 0, 0, 0};
        vt[3]  = '{4'h6, 2'd2, 2'd3, 8'h00, 16'hF0F0, 16'h0FF0, 16'h00F0, 1, 0, 0, 0};
        vt[4]  = '{4'h7, 2'd0, 2'd2, 8'h00, 16'h1200, 16'h0034, 16'h1234, 1, 0, 0, 0};
        vt[5]  = '{4'h8, 2'd1, 2'd2, 8'h00, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 1, 0, 0};
        vt[6]  = '{4'h9, 2'd0, 2'd1, 8'h04, 16'h1234, 16'h0000, 16'h2340, 0, 0, 0, 0};
        vt[7]  = '{4'hA, 2'd3, 2'd0, 8'h13, 16'h8000, 16'h0000, 16'h1000, 0, 0, 0, 0};
        vt[8]  = '{4'h1, 2'd2, 2'd0, 8'hA5, 16'hFFFF, 16'h0000, 16'h00A5, 0, 0, 0, 0};
        vt[9]  = '{4'h2, 2'd1, 2'd0, 8'h5A, 16'h1234, 16'h0000, 16'h5A34, 0, 0, 0, 0};
        vt[10] = '{4'h3, 2'd3, 2'd0, 8'h00, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0};
        vt[11] = '{4'h5, 2'd2, 2'd3, 8'h00, 16'h0001, 16'h0002, 16'hFFFF, 1, 0, 1, 1};
        vt[12] = '{4'hC, 2'd2, 2'd1, 8'h00, 16'h0005, 16'h0005, 16'h0005, 1, 1, 1, 0};
        vt[13] = '{4'h4, 2'd1, 2'd1, 8'h00, 16'h8001, 16'h8001, 16'h0002, 1, 0, 1, 1};
        vt[14] = '{4'hB, 2'd0, 2'd0, 8'h00, 16'h00FF, 16'h00FF, 16'hFE01, 1, 0, 0, 0};
        vt[15] = '{4'h0, 2'd1, 2'd2, 8'h00, 16'h7777, 16'h0000, 16'h7777, 0, 0, 0, 0};
        vt[16] = '{4'h4, 2'd2, 2'd3, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rs", rs, 0);
        chk_state("rst");

        // ---------------- LDI r2,0xA5 right after reset ----------------
        run(16'h18A5, 1'b0);
        chk("ldi_r2", rf[2], 16'h00A5);

        // ---------------- table-driven vectors ----------------
        foreach (vt[i]) begin
            load(vt[i].rs, vt[i].b);
            load(vt[i].rd, vt[i].a);
            run({vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm}, 1'b0);
            chk($sformatf("vec%0d_val", i), rf[vt[i].rd], vt[i].ev);
            if (vt[i].cz) chk($sformatf("vec%0d_z", i), flag_z, vt[i].ez);
            if (vt[i].cc) chk($sformatf("vec%0d_c", i), flag_c, vt[i].ec);
        end

        // ---------------- idle hold, then CMP r2,r2 ----------------
        load(2'd0, 16'h1111); load(2'd1, 16'h2222);
        load(2'd2, 16'h3333); load(2'd3, 16'h4444);
        repeat (50) @(negedge clk);
        chk_state("idle50");
        run(16'hCA00, 1'b0);
        chk("cmp_z", flag_z, 1);
        chk("cmp_c", flag_c, 0);
        chk("cmp_r2", rf[2], 16'h3333);

        // ---------------- illegal opcode, in_valid held during MUL ----------------
        run(16'hE5FF, 1'b0);
        run(16'hB400, 1'b1);   // MUL r1,r0 with LDI r0,FF presented while busy
        chk("mul_hold_r0", rf[0], 16'h1111);

        // ---------------- reset in the middle of MUL ----------------
        load(2'd1, 16'h0003);
        load(2'd3, 16'h1234);
        @(negedge clk);
        in_valid = 1'b1; in_instr = 16'hBD00;   // MUL r3,r1
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mul_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mz = 1'b0; mc = 1'b0;
        @(negedge clk);
        chk("arst_ready", in_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_r3", rf[3], 16'h1234);
        chk_state("arst");

        // ---------------- random instructions ----------------
        for (int n = 0; n < 150; n++) begin
            logic [15:0] w;
            w = 16'($urandom);
            run(w, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
